// File: rtl/draw_arbiter_pkg.sv
// Shared types and defaults for the draw-engine arbiter.
package draw_arbiter_pkg;

  localparam logic ITEM_PRESS = 1'b1;
  localparam logic ITEM_GARB  = 1'b0;

  localparam int unsigned CNT_W = 12;
  localparam int unsigned POS_W = 3;

  localparam int unsigned PRESS_CYCLES_DEF = 2402;
  localparam int unsigned GARB_CYCLES_DEF  = 402;
  localparam int unsigned PRESS_MAXPOS_DEF = 5;
  localparam int unsigned GARB_MAXPOS_DEF  = 3;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic             item;
    logic             erase;
    logic [POS_W-1:0] pos;
  } cmd_t;

  // Position range depends on which sprite is being drawn.
  function automatic logic pos_legal(input cmd_t c,
                                     input logic [POS_W-1:0] press_max,
                                     input logic [POS_W-1:0] garb_max);
    return (c.item == ITEM_PRESS) ? (c.pos <= press_max) : (c.pos <= garb_max);
  endfunction

endpackage

// File: rtl/draw_arbiter_if.sv
// Requester/engine bundle between the two sprite FSMs and the draw arbiter.
interface draw_arbiter_if;
  import draw_arbiter_pkg::*;

  logic             req0, req1;
  logic             item0, item1;
  logic             erase0, erase1;
  logic [POS_W-1:0] pos0, pos1;
  logic             ack0, ack1;
  logic             done0, done1;
  logic             err0, err1;
  logic             draw_item;
  logic             draw_erase;
  logic [POS_W-1:0] draw_pos;
  logic             busy;

  modport master (
    output req0, req1, item0, item1, erase0, erase1, pos0, pos1,
    input  ack0, ack1, done0, done1, err0, err1,
    input  draw_item, draw_erase, draw_pos, busy
  );

  modport slave (
    input  req0, req1, item0, item1, erase0, erase1, pos0, pos1,
    output ack0, ack1, done0, done1, err0, err1,
    output draw_item, draw_erase, draw_pos, busy
  );
endinterface

// File: rtl/draw_arbiter_rr_arb2.sv
// Two-way picker (round-robin or fixed priority) with its last-grant register.
module rr_arb2 #(
  parameter int unsigned PRIO_MODE = 0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic       gnt_valid_c,
  output logic       gnt_idx_c
);

  logic last;

  // last resets to 1 so requester 0 wins the first contested round.
  always_ff @(posedge clk) begin
    if (!reset_n)    last <= 1'b1;
    else if (update) last <= upd_idx;
  end

  always_comb begin
    gnt_valid_c = |req;
    if (PRIO_MODE != 0)   gnt_idx_c = ~req[0];
    else if (&req)        gnt_idx_c = ~last;
    else                  gnt_idx_c = req[1];
  end

endmodule

// File: rtl/draw_arbiter.sv
// Serialises erase/draw commands from two requesters onto the single draw engine.
module draw_arbiter
  import draw_arbiter_pkg::*;
#(
  parameter int unsigned PRESS_CYCLES = PRESS_CYCLES_DEF,
  parameter int unsigned GARB_CYCLES  = GARB_CYCLES_DEF,
  parameter int unsigned PRESS_MAXPOS = PRESS_MAXPOS_DEF,
  parameter int unsigned GARB_MAXPOS  = GARB_MAXPOS_DEF,
  parameter int unsigned PRIO_MODE    = 0
) (
  input logic           CLOCK_50,
  input logic           reset_n,
  draw_arbiter_if.slave bus
);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             owner, owner_nxt;
  cmd_t             draw_cmd, draw_cmd_nxt;
  logic             ack0, ack1, err0, err1, done0, done1, busy;
  logic             ack0_nxt, ack1_nxt, err0_nxt, err1_nxt, done0_nxt, done1_nxt, busy_nxt;

  cmd_t             cmd0_c, cmd1_c, win_c;
  logic [1:0]       req_c;
  logic             gnt_valid_c, gnt_idx_c, legal_c, accept_c, run_done_c;
  logic [CNT_W-1:0] len_m1_c;

  assign cmd0_c = '{item: bus.item0, erase: bus.erase0, pos: bus.pos0};
  assign cmd1_c = '{item: bus.item1, erase: bus.erase1, pos: bus.pos1};

  // A request still high in its own ack cycle has already been served.
  assign req_c = (state == S_IDLE) ? {bus.req1 & ~ack1, bus.req0 & ~ack0} : 2'b00;

  rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_rr_arb2 (
    .clk         (CLOCK_50),
    .reset_n     (reset_n),
    .req         (req_c),
    .update      (accept_c),
    .upd_idx     (gnt_idx_c),
    .gnt_valid_c (gnt_valid_c),
    .gnt_idx_c   (gnt_idx_c)
  );

  assign win_c      = gnt_idx_c ? cmd1_c : cmd0_c;
  assign legal_c    = pos_legal(win_c, POS_W'(PRESS_MAXPOS), POS_W'(GARB_MAXPOS));
  assign accept_c   = gnt_valid_c & legal_c;
  assign len_m1_c   = (draw_cmd.item == ITEM_PRESS) ? CNT_W'(PRESS_CYCLES - 1)
                                                    : CNT_W'(GARB_CYCLES - 1);
  assign run_done_c = (state == S_WAIT) && (cnt == len_m1_c);

  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (accept_c)   state_nxt = S_WAIT;
      S_WAIT:  if (run_done_c) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ack0_nxt     = 1'b0;
    ack1_nxt     = 1'b0;
    err0_nxt     = 1'b0;
    err1_nxt     = 1'b0;
    done0_nxt    = 1'b0;
    done1_nxt    = 1'b0;
    busy_nxt     = busy;
    draw_cmd_nxt = draw_cmd;
    owner_nxt    = owner;
    cnt_nxt      = cnt;
    unique case (state)
      S_IDLE: begin
        if (gnt_valid_c) begin
          ack0_nxt = ~gnt_idx_c;
          ack1_nxt = gnt_idx_c;
          err0_nxt = ~gnt_idx_c & ~legal_c;
          err1_nxt = gnt_idx_c & ~legal_c;
          if (legal_c) begin
            draw_cmd_nxt = win_c;
            owner_nxt    = gnt_idx_c;
            cnt_nxt      = '0;
            busy_nxt     = 1'b1;
          end
        end
      end
      S_WAIT: begin
        if (run_done_c) begin
          done0_nxt = ~owner;
          done1_nxt = owner;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Reset aborts a run silently; the engine has its own reset.
  always_ff @(posedge CLOCK_50) begin
    if (!reset_n) begin
      {ack0, ack1, err0, err1, done0, done1, busy} <= '0;
      draw_cmd <= '0;
      owner    <= 1'b0;
      cnt      <= '0;
    end else begin
      ack0     <= ack0_nxt;
      ack1     <= ack1_nxt;
      err0     <= err0_nxt;
      err1     <= err1_nxt;
      done0    <= done0_nxt;
      done1    <= done1_nxt;
      busy     <= busy_nxt;
      draw_cmd <= draw_cmd_nxt;
      owner    <= owner_nxt;
      cnt      <= cnt_nxt;
    end
  end

  assign bus.ack0       = ack0;
  assign bus.ack1       = ack1;
  assign bus.err0       = err0;
  assign bus.err1       = err1;
  assign bus.done0      = done0;
  assign bus.done1      = done1;
  assign bus.busy       = busy;
  assign bus.draw_item  = draw_cmd.item;
  assign bus.draw_erase = draw_cmd.erase;
  assign bus.draw_pos   = draw_cmd.pos;

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: one round-robin and one fixed-priority instance.
module tb_draw_arbiter;
  import draw_arbiter_pkg::*;

  logic CLOCK_50 = 1'b0;
  logic reset_n  = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  always #10 CLOCK_50 = ~CLOCK_50;

  draw_arbiter_if bus_rr ();
  draw_arbiter_if bus_fp ();

  draw_arbiter #(.PRIO_MODE(0)) dut_rr (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus_rr));
  draw_arbiter #(.PRIO_MODE(1)) dut_fp (.CLOCK_50(CLOCK_50), .reset_n(reset_n), .bus(bus_fp));

  task automatic clear_inputs();
    {bus_rr.req0, bus_rr.req1, bus_rr.item0, bus_rr.item1, bus_rr.erase0, bus_rr.erase1} = '0;
    {bus_fp.req0, bus_fp.req1, bus_fp.item0, bus_fp.item1, bus_fp.erase0, bus_fp.erase1} = '0;
    bus_rr.pos0 = '0; bus_rr.pos1 = '0; bus_fp.pos0 = '0; bus_fp.pos1 = '0;
  endtask

  task automatic do_reset();
    @(negedge CLOCK_50);
    reset_n = 1'b0;
    clear_inputs();
    @(negedge CLOCK_50);
    @(negedge CLOCK_50);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] v;
    do_reset();
    v = {bus_rr.ack0, bus_rr.ack1, bus_rr.done0, bus_rr.done1, bus_rr.err0, bus_rr.err1,
         bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos, bus_rr.busy};
    checks++;
    if (v !== 13'd0) begin errors++; $display("FAIL reset_rr outputs got %b exp 0", v); end
    v = {bus_fp.ack0, bus_fp.ack1, bus_fp.done0, bus_fp.done1, bus_fp.err0, bus_fp.err1,
         bus_fp.draw_item, bus_fp.draw_erase, bus_fp.draw_pos, bus_fp.busy};
    checks++;
    if (v !== 13'd0) begin errors++; $display("FAIL reset_fp outputs got %b exp 0", v); end
  endtask

  task automatic test_single_press();
    int n;
    bit stable;
    do_reset();
    bus_rr.req0 = 1'b1; bus_rr.item0 = 1'b1; bus_rr.erase0 = 1'b0; bus_rr.pos0 = 3'd2;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.ack1, bus_rr.err0, bus_rr.busy} !== 4'b1001) begin
      errors++; $display("FAIL press_ack ack0/ack1/err0/busy got %b exp 1001",
                         {bus_rr.ack0, bus_rr.ack1, bus_rr.err0, bus_rr.busy});
    end
    checks++;
    if ({bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos} !== 5'b10010) begin
      errors++; $display("FAIL press_draw got %b exp 10010",
                         {bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos});
    end
    bus_rr.req0 = 1'b0;
    n = 0; stable = 1'b1;
    do begin
      @(negedge CLOCK_50); n++;
      if ({bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos} !== 5'b10010) stable = 1'b0;
    end while (!bus_rr.done0 && n < 3000);
    checks++;
    if (n !== 2402 || bus_rr.done0 !== 1'b1) begin
      errors++; $display("FAIL press_done_latency got %0d exp 2402 (done0=%b)", n, bus_rr.done0);
    end
    checks++;
    if (bus_rr.busy !== 1'b0) begin errors++; $display("FAIL press_busy_at_done got %b exp 0", bus_rr.busy); end
    checks++;
    if (!stable) begin errors++; $display("FAIL press_draw_stable got changed exp held"); end
  endtask

  task automatic test_rr_both();
    int n;
    do_reset();
    bus_rr.req0 = 1'b1; bus_rr.item0 = 1'b1; bus_rr.erase0 = 1'b1; bus_rr.pos0 = 3'd1;
    bus_rr.req1 = 1'b1; bus_rr.item1 = 1'b0; bus_rr.erase1 = 1'b0; bus_rr.pos1 = 3'd3;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.ack1} !== 2'b10) begin
      errors++; $display("FAIL rr_first ack0/ack1 got %b exp 10", {bus_rr.ack0, bus_rr.ack1});
    end
    bus_rr.req0 = 1'b0;
    n = 0;
    do begin
      @(negedge CLOCK_50); n++;
      if (bus_rr.ack1) break;
    end while (!bus_rr.done0 && n < 3000);
    checks++;
    if (bus_rr.done0 !== 1'b1 || n !== 2402) begin
      errors++; $display("FAIL rr_done0 got n=%0d done0=%b exp 2402/1", n, bus_rr.done0);
    end
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.ack1, bus_rr.draw_item, bus_rr.draw_pos} !== 6'b010011) begin
      errors++; $display("FAIL rr_second got %b exp 010011",
                         {bus_rr.ack0, bus_rr.ack1, bus_rr.draw_item, bus_rr.draw_pos});
    end
    bus_rr.req1 = 1'b0;
    n = 0;
    do begin @(negedge CLOCK_50); n++; end while (!bus_rr.done1 && n < 500);
    checks++;
    if (bus_rr.done1 !== 1'b1 || n !== 402) begin
      errors++; $display("FAIL rr_done1 got n=%0d done1=%b exp 402/1", n, bus_rr.done1);
    end
    bus_rr.req0 = 1'b1; bus_rr.req1 = 1'b1;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.ack1} !== 2'b10) begin
      errors++; $display("FAIL rr_rotate ack0/ack1 got %b exp 10", {bus_rr.ack0, bus_rr.ack1});
    end
    bus_rr.req0 = 1'b0; bus_rr.req1 = 1'b0;
  endtask

  task automatic test_fixed_prio();
    int a0, a1, n;
    do_reset();
    bus_fp.req0 = 1'b1; bus_fp.item0 = 1'b0; bus_fp.pos0 = 3'd0;
    bus_fp.req1 = 1'b1; bus_fp.item1 = 1'b0; bus_fp.pos1 = 3'd1;
    a0 = 0; a1 = 0;
    for (int i = 0; i < 1300; i++) begin
      @(negedge CLOCK_50);
      if (bus_fp.ack0) a0++;
      if (bus_fp.ack1) a1++;
    end
    checks++;
    if (a1 !== 0) begin errors++; $display("FAIL fp_starve ack1 count got %0d exp 0", a1); end
    checks++;
    if (a0 !== 4) begin errors++; $display("FAIL fp_ack0_count got %0d exp 4", a0); end
    bus_fp.req0 = 1'b0;
    n = 0;
    do begin @(negedge CLOCK_50); n++; end while (!bus_fp.ack1 && n < 500);
    checks++;
    if (bus_fp.ack1 !== 1'b1) begin errors++; $display("FAIL fp_req1_after got ack1=%b exp 1", bus_fp.ack1); end
    bus_fp.req1 = 1'b0;
  endtask

  task automatic test_illegal_pos();
    int n;
    bit seen;
    do_reset();
    bus_rr.req0 = 1'b1; bus_rr.item0 = 1'b0; bus_rr.erase0 = 1'b0; bus_rr.pos0 = 3'd4;
    bus_rr.req1 = 1'b1; bus_rr.item1 = 1'b0; bus_rr.erase1 = 1'b1; bus_rr.pos1 = 3'd2;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.err0, bus_rr.ack1, bus_rr.busy} !== 4'b1100) begin
      errors++; $display("FAIL err_then_next ack0/err0/ack1/busy got %b exp 1100",
                         {bus_rr.ack0, bus_rr.err0, bus_rr.ack1, bus_rr.busy});
    end
    bus_rr.req0 = 1'b0;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack1, bus_rr.err1, bus_rr.busy, bus_rr.draw_pos} !== 6'b101010) begin
      errors++; $display("FAIL err_next_grant ack1/err1/busy/pos got %b exp 101010",
                         {bus_rr.ack1, bus_rr.err1, bus_rr.busy, bus_rr.draw_pos});
    end
    bus_rr.req1 = 1'b0;
    n = 0;
    do begin @(negedge CLOCK_50); n++; end while (!bus_rr.done1 && n < 500);
    bus_rr.req1 = 1'b1; bus_rr.erase1 = 1'b0; bus_rr.pos1 = 3'd5;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack1, bus_rr.err1, bus_rr.busy} !== 3'b110) begin
      errors++; $display("FAIL garb_pos5 ack1/err1/busy got %b exp 110",
                         {bus_rr.ack1, bus_rr.err1, bus_rr.busy});
    end
    checks++;
    if ({bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos} !== 5'b01010) begin
      errors++; $display("FAIL garb_pos5_draw got %b exp 01010",
                         {bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos});
    end
    bus_rr.req1 = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLOCK_50);
      if (bus_rr.done1 || bus_rr.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL garb_pos5_no_run got activity exp none"); end
    bus_rr.req0 = 1'b1; bus_rr.item0 = 1'b1; bus_rr.pos0 = 3'd6;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.err0, bus_rr.busy} !== 3'b110) begin
      errors++; $display("FAIL press_pos6 ack0/err0/busy got %b exp 110",
                         {bus_rr.ack0, bus_rr.err0, bus_rr.busy});
    end
    bus_rr.req0 = 1'b0;
    @(negedge CLOCK_50);
    bus_rr.req0 = 1'b1; bus_rr.pos0 = 3'd5;
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.err0, bus_rr.busy, bus_rr.draw_pos} !== 6'b101101) begin
      errors++; $display("FAIL press_pos5 ack0/err0/busy/pos got %b exp 101101",
                         {bus_rr.ack0, bus_rr.err0, bus_rr.busy, bus_rr.draw_pos});
    end
    bus_rr.req0 = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [12:0] v;
    bit seen;
    do_reset();
    bus_rr.req1 = 1'b1; bus_rr.item1 = 1'b0; bus_rr.erase1 = 1'b1; bus_rr.pos1 = 3'd1;
    @(negedge CLOCK_50);
    bus_rr.req1 = 1'b0;
    repeat (200) @(negedge CLOCK_50);
    reset_n = 1'b0;
    @(negedge CLOCK_50);
    v = {bus_rr.ack0, bus_rr.ack1, bus_rr.done0, bus_rr.done1, bus_rr.err0, bus_rr.err1,
         bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos, bus_rr.busy};
    checks++;
    if (v !== 13'd0) begin errors++; $display("FAIL midwait_reset outputs got %b exp 0", v); end
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge CLOCK_50);
      if (bus_rr.done1 || bus_rr.busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin errors++; $display("FAIL midwait_no_done got activity exp none"); end
  endtask

  task automatic test_back_to_back();
    int n;
    bit stable, early;
    do_reset();
    bus_rr.req1 = 1'b1; bus_rr.item1 = 1'b0; bus_rr.erase1 = 1'b1; bus_rr.pos1 = 3'd3;
    @(negedge CLOCK_50);
    checks++;
    if (bus_rr.ack1 !== 1'b1) begin errors++; $display("FAIL b2b_ack1 got %b exp 1", bus_rr.ack1); end
    bus_rr.req1 = 1'b0;
    bus_rr.req0 = 1'b1; bus_rr.item0 = 1'b1; bus_rr.erase0 = 1'b0; bus_rr.pos0 = 3'd4;
    n = 0; stable = 1'b1; early = 1'b0;
    do begin
      @(negedge CLOCK_50); n++;
      if ({bus_rr.draw_item, bus_rr.draw_erase, bus_rr.draw_pos} !== 5'b01011) stable = 1'b0;
      if (bus_rr.ack0) early = 1'b1;
    end while (!bus_rr.done1 && n < 500);
    checks++;
    if (bus_rr.done1 !== 1'b1 || n !== 402 || !stable || early) begin
      errors++; $display("FAIL b2b_wait n=%0d done1=%b stable=%b early_ack0=%b exp 402/1/1/0",
                         n, bus_rr.done1, stable, early);
    end
    @(negedge CLOCK_50);
    checks++;
    if ({bus_rr.ack0, bus_rr.busy, bus_rr.draw_item, bus_rr.draw_pos} !== 6'b111100) begin
      errors++; $display("FAIL b2b_ack0 ack0/busy/item/pos got %b exp 111100",
                         {bus_rr.ack0, bus_rr.busy, bus_rr.draw_item, bus_rr.draw_pos});
    end
    bus_rr.req0 = 1'b0;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_press();
    test_rr_both();
    test_fixed_prio();
    test_illegal_pos();
    test_reset_mid_wait();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
